// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with RXDATA/STATUS registers and a level irq.
// Define UART_RX_PARITY_EN to expect one even-parity bit after data bit 7.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       readEnable,
    input  logic       writeEnable,
    input  logic [1:0] regSelect,
    input  logic [7:0] writeData,
    output logic [7:0] Data,
    output logic       irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      rxdata_q, rxdata_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            perr_bit;
    logic            sync1_q, sync2_q, prev_q;
    logic            fall;
    logic            rd_clr;
    logic            wr_status;
    logic            busy;
    logic [7:0]      status;
    logic [7:0]      rd_data;

    // Both flops and the edge register idle high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            rxdata_q <= '0;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= rx;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            rxdata_q <= rxdata_d;
            ready_q  <= ready_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic unused_wd;
    assign unused_wd = ^{writeData[7:5], writeData[1]};

    always_ff @(posedge clk) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= perr_d;
    end
    assign perr_bit = perr_q;
`else
    logic unused_wd;
    assign unused_wd = ^{writeData[7:4], writeData[1]};
    assign perr_bit  = 1'b0;
`endif

    assign fall      = prev_q & ~sync2_q;
    assign rd_clr    = readEnable && (regSelect == 2'b00);
    assign wr_status = writeEnable && (regSelect == 2'b01);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        rxdata_d = rxdata_q;
        // Clears first; FSM sets below override them so set wins on a collision.
        ready_d  = ready_q & ~rd_clr & ~(wr_status & writeData[0]);
        ferr_d   = ferr_q & ~(wr_status & writeData[2]);
        ovr_d    = ovr_q & ~(wr_status & writeData[3]);
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_q & ~(wr_status & writeData[4]);
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    if (^{shreg_q, sync2_q}) perr_d = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (sync2_q) begin
                        // A read of RXDATA on this edge frees the register for the new byte.
                        if (!ready_q || rd_clr) begin
                            rxdata_d = shreg_q;
                            ready_d  = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign status = {3'b000, perr_bit, ovr_q, ferr_q, busy, ready_q};
    assign irq    = ready_q;

    always_comb begin
        rd_data = 8'h00;
        case (regSelect)
            2'b00:   rd_data = rxdata_q;
            2'b01:   rd_data = status;
            default: rd_data = 8'h00;
        endcase
    end

    assign Data = readEnable ? rd_data : 8'bz;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; inputs change on the falling clock edge.
module tb_uart_rx;

    localparam int CLKS = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       read_en;
    logic       write_en;
    logic [1:0] reg_sel;
    logic [7:0] write_data;
    wire  [7:0] data_w;
    logic       irq;

    int checks = 0;
    int passes = 0;
    logic [7:0] val;

    uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .readEnable(read_en),
        .writeEnable(write_en),
        .regSelect(reg_sel),
        .writeData(write_data),
        .Data(data_w),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    // Samples a register within the low clock phase, so no edge sees the read strobe.
    task automatic peek(input logic [1:0] sel, output logic [7:0] v);
        read_en = 1'b1;
        reg_sel = sel;
        #1;
        v = data_w;
        read_en = 1'b0;
    endtask

    task automatic consume_rx();
        read_en = 1'b1;
        reg_sel = 2'b00;
        @(negedge clk);
        read_en = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] sel, input logic [7:0] v);
        write_en   = 1'b1;
        reg_sel    = sel;
        write_data = v;
        @(negedge clk);
        write_en   = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_head(d);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
    endtask

    initial begin
        rx = 1'b1; reset = 1'b1; read_en = 1'b0; write_en = 1'b0;
        reg_sel = 2'b00; write_data = 8'h00;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        peek(2'b01, val); check("reset_status", val, 8'h00);
        peek(2'b00, val); check("reset_rxdata", val, 8'h00);
        check("reset_irq", {7'b0, irq}, 8'h00);

        // 0xA5: irq must rise exactly on the stop-bit midpoint edge
        send_head(8'hA5);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("a5_irq_before_mid", {7'b0, irq}, 8'h00);
        @(negedge clk);
        check("a5_irq_at_mid", {7'b0, irq}, 8'h01);
        peek(2'b01, val); check("a5_status", val, 8'h01);
        peek(2'b00, val); check("a5_rxdata", val, 8'hA5);
        repeat (5) @(negedge clk);
        consume_rx();
        peek(2'b01, val); check("a5_after_read", val, 8'h00);
        check("a5_irq_after_read", {7'b0, irq}, 8'h00);

        // glitch shorter than half a bit
        rx = 1'b0;
        repeat (5) @(negedge clk);
        peek(2'b01, val); check("glitch_busy", val, 8'h02);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        peek(2'b01, val); check("glitch_idle", val, 8'h00);

        // overrun
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        peek(2'b01, val); check("ovr_status", val, 8'h09);
        peek(2'b00, val); check("ovr_rxdata", val, 8'h3C);
        check("ovr_irq", {7'b0, irq}, 8'h01);
        write_reg(2'b00, 8'hFF);
        peek(2'b01, val); check("wr_rxdata_ignored", val, 8'h09);
        write_reg(2'b01, 8'h08);
        peek(2'b01, val); check("w1c_ovr", val, 8'h01);
        write_reg(2'b01, 8'h02);
        peek(2'b01, val); check("busy_read_only", val, 8'h01);
        peek(2'b10, val); check("reserved_10", val, 8'h00);
        peek(2'b11, val); check("reserved_11", val, 8'h00);
        consume_rx();
        peek(2'b01, val); check("ovr_after_read", val, 8'h00);

        // byte completes on the same edge that reads RXDATA
        send_frame(8'h66, 1'b1);
        peek(2'b01, val); check("pre_sim_status", val, 8'h01);
        send_head(8'h99);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        rx = 1'b1;
        repeat (10) @(negedge clk);
        read_en = 1'b1;
        reg_sel = 2'b00;
        @(negedge clk);
        read_en = 1'b0;
        peek(2'b01, val); check("sim_status", val, 8'h01);
        peek(2'b00, val); check("sim_rxdata", val, 8'h99);
        repeat (5) @(negedge clk);
        write_reg(2'b01, 8'h01);
        peek(2'b01, val); check("w1c_ready", val, 8'h00);

        // framing error followed by a long break
        send_head(8'h55);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        rx = 1'b0;
        repeat (11) @(negedge clk);
        peek(2'b01, val); check("ferr_status", val, 8'h04);
        peek(2'b00, val); check("ferr_rxdata", val, 8'h99);
        repeat (200) @(negedge clk);
        peek(2'b01, val); check("break_mid", val, 8'h04);
        write_reg(2'b01, 8'h04);
        peek(2'b01, val); check("w1c_ferr", val, 8'h00);
        repeat (430) @(negedge clk);
        peek(2'b01, val); check("break_no_refire", val, 8'h00);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        peek(2'b01, val); check("break_release", val, 8'h00);

        // reset during data bit 4 of 0xFF
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (8) @(negedge clk);
        peek(2'b01, val); check("pre_reset_busy", val, 8'h02);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        peek(2'b01, val); check("midreset_status", val, 8'h00);
        peek(2'b00, val); check("midreset_rxdata", val, 8'h00);
        repeat (CLKS * 6) @(negedge clk);
        peek(2'b01, val); check("midreset_quiet", val, 8'h00);
        send_frame(8'h12, 1'b1);
        peek(2'b01, val); check("post_reset_status", val, 8'h01);
        peek(2'b00, val); check("post_reset_rxdata", val, 8'h12);
        consume_rx();

`ifdef UART_RX_PARITY_EN
        send_head(8'h07);
        send_bit(1'b0);
        send_bit(1'b1);
        peek(2'b01, val); check("perr_status", val, 8'h11);
        peek(2'b00, val); check("perr_rxdata", val, 8'h07);
        write_reg(2'b01, 8'h10);
        peek(2'b01, val); check("w1c_perr", val, 8'h01);
        consume_rx();
        send_head(8'h07);
        send_bit(1'b1);
        send_bit(1'b1);
        peek(2'b01, val); check("parity_ok_status", val, 8'h01);
        peek(2'b00, val); check("parity_ok_rxdata", val, 8'h07);
`else
        write_reg(2'b01, 8'h10);
        peek(2'b01, val); check("no_perr", val, 8'h00);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
